// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    CSUM,
    RELEASE,
    RUN,
    ERROR
  } state_t;

  // A length byte of zero stands for a full 256-byte image.
  localparam int         LOADER_LEN_FULL = 0;
  localparam logic [7:0] LOADER_CSUM_OK  = 8'h00;

  function automatic logic takes_bytes(state_t s);
    return (s == IDLE) || (s == ADDR) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte stream in and memory write port out, bundled for the loader.
interface prog_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/loader_csum.sv
// Running 8-bit sum of payload bytes; ok reports whether sum plus data is zero.
module loader_csum
  import prog_loader_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         add_en,
  input  logic [W-1:0] data,
  output logic         ok
);

  logic [W-1:0] acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        acc <= '0;
    else if (clr)    acc <= '0;
    else if (add_en) acc <= acc + data;
  end

  // Evaluated against the byte currently offered, so the CSUM byte is judged on its accept edge.
  assign ok = ((acc + data) == W'(LOADER_CSUM_OK));

endmodule

// File: rtl/prog_loader.sv
// Frame loader: LEN, START_ADDR, payload [, CSUM] -> memory writes, then core release.
// Optional checksum stage enabled by defining LOADER_CSUM_EN.
//   state   | meaning
//   IDLE    | waiting for LEN
//   ADDR    | waiting for START_ADDR
//   DATA    | one memory write per accepted payload byte
//   CSUM    | checking trailing checksum byte
//   RELEASE | holding core in reset for HOLD_CYCLES
//   RUN     | core running, done high
//   ERROR   | bad checksum, core held, err high
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 3
) (
  input  logic            clk,
  input  logic            rst,
  prog_loader_if.slave    bus,
  input  logic            reload,
  output logic            cpu_rst,
  output logic            done,
  output logic            err
);

  localparam int LEN_W  = DATA_W + 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  len_cnt;
  logic [ADDR_W-1:0] addr;
  logic [HOLD_W-1:0] hold_cnt;
  logic              accept;
  logic              last_byte;
  logic              csum_ok;

  assign accept    = bus.in_valid && bus.in_ready;
  assign last_byte = (len_cnt == LEN_W'(1));

`ifdef LOADER_CSUM_EN
  loader_csum #(.W(DATA_W)) u_csum (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == IDLE),
    .add_en (state == DATA && accept),
    .data   (bus.in_data),
    .ok     (csum_ok)
  );
`else
  assign csum_ok = 1'b1;
`endif

  // in_ready is registered from the next state so it reads 0 while reset is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      bus.in_ready <= 1'b0;
    end else begin
      state        <= state_nxt;
      bus.in_ready <= takes_bytes(state_nxt);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ADDR;
      ADDR:    if (accept) state_nxt = DATA;
`ifdef LOADER_CSUM_EN
      DATA:    if (accept && last_byte) state_nxt = CSUM;
      CSUM:    if (accept) state_nxt = csum_ok ? RELEASE : ERROR;
`else
      DATA:    if (accept && last_byte) state_nxt = RELEASE;
`endif
      RELEASE: if (hold_cnt == '0) state_nxt = RUN;
      RUN,
      ERROR:   if (reload) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cpu_rst = (state == RUN);
    done    = (state == RUN);
`ifdef LOADER_CSUM_EN
    err     = (state == ERROR);
`else
    err     = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_cnt       <= '0;
      addr          <= '0;
      hold_cnt      <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      case (state)
        IDLE: if (accept)
          len_cnt <= (bus.in_data == DATA_W'(LOADER_LEN_FULL)) ? LEN_W'(1 << DATA_W)
                                                                : LEN_W'(bus.in_data);
        ADDR: if (accept) addr <= ADDR_W'(bus.in_data);
        DATA: if (accept) begin
          bus.mem_we    <= 1'b1;
          bus.mem_addr  <= addr;
          bus.mem_wdata <= bus.in_data;
          addr          <= addr + 1'b1;
          len_cnt       <= len_cnt - 1'b1;
        end
        default: ;
      endcase
      if (state_nxt == RELEASE && state != RELEASE)
        hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
      else if (state == RELEASE && hold_cnt != '0)
        hold_cnt <= hold_cnt - 1'b1;
    end
  end

  // csum_ok is only consulted when the checksum stage exists.
  logic unused_ok;
  assign unused_ok = csum_ok;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: framing, wrap, stalls, reset abort, full 256-byte image.
module tb_prog_loader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic reload = 1'b0;
  logic cpu_rst, done, err;

  int compared   = 0;
  int mismatched = 0;

  prog_loader_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  prog_loader #(.ADDR_W(8), .DATA_W(8), .HOLD_CYCLES(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .reload  (reload),
    .cpu_rst (cpu_rst),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  logic [7:0] wlog_addr [1024];
  logic [7:0] wlog_data [1024];
  int         wlog_cyc  [1024];
  int         wcnt = 0;
  int         cyc  = 0;
  logic [7:0] pay  [256];
  bit         watch = 1'b0;
  int         cpu_rst_high = 0;

  always @(posedge clk) begin
    if (bus.mem_we === 1'b1 && wcnt < 1024) begin
      mem[bus.mem_addr] = bus.mem_wdata;
      wlog_addr[wcnt]   = bus.mem_addr;
      wlog_data[wcnt]   = bus.mem_wdata;
      wlog_cyc[wcnt]    = cyc;
      wcnt++;
    end
    cyc++;
  end

  always @(negedge clk) if (watch && cpu_rst !== 1'b0) cpu_rst_high++;

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL send_byte_timeout: in_ready=%b required 1", bus.in_ready);
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input int len, input logic [7:0] a, input bit gap,
                            input logic [7:0] csum_flip);
    logic [7:0] s = 8'h00;
    send_byte(8'(len));
    send_byte(a);
    for (int i = 0; i < len; i++) begin
      send_byte(pay[i]);
      s = s + pay[i];
      if (gap) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
    end
`ifdef LOADER_CSUM_EN
    send_byte((~s + 8'h01) ^ csum_flip);
`else
    if (csum_flip != 8'h00) s = s ^ csum_flip;
`endif
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if ({bus.in_ready, bus.mem_we, cpu_rst, done, err} !== 5'b00000) begin
      mismatched++;
      $display("FAIL reset_flags: rdy/we/cpu_rst/done/err=%b required 00000",
               {bus.in_ready, bus.mem_we, cpu_rst, done, err});
    end
    compared++;
    if ({bus.mem_addr, bus.mem_wdata} !== 16'h0000) begin
      mismatched++;
      $display("FAIL reset_mem_bus: addr/wdata=%h required 0000", {bus.mem_addr, bus.mem_wdata});
    end
    rst = 1'b1;
    @(negedge clk);
    compared++;
    if (bus.in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_ready_after: in_ready=%b required 1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    int w0 = wcnt;
    pay[0] = 8'h02; pay[1] = 8'h11; pay[2] = 8'h22;
    send_frame(3, 8'h00, 1'b0, 8'h00);
    compared++;
    if (bus.in_ready !== 1'b0 || cpu_rst !== 1'b0) begin
      mismatched++;
      $display("FAIL basic_release_entry: in_ready=%b cpu_rst=%b required 0 0", bus.in_ready, cpu_rst);
    end
    repeat (2) @(negedge clk);
    compared++;
    if (cpu_rst !== 1'b0 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL basic_hold_early: cpu_rst=%b done=%b required 0 0", cpu_rst, done);
    end
    @(negedge clk);
    compared++;
    if (cpu_rst !== 1'b1 || done !== 1'b1 || err !== 1'b0) begin
      mismatched++;
      $display("FAIL basic_release: cpu_rst=%b done=%b err=%b required 1 1 0", cpu_rst, done, err);
    end
    compared++;
    if (wcnt - w0 !== 3) begin
      mismatched++;
      $display("FAIL basic_write_count: got %0d required 3", wcnt - w0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        compared++;
        if (wlog_addr[w0+i] !== 8'(i) || wlog_data[w0+i] !== pay[i] ||
            (i > 0 && wlog_cyc[w0+i] !== wlog_cyc[w0+i-1] + 1)) begin
          mismatched++;
          $display("FAIL basic_write%0d: addr=%h data=%h required %h %h consecutive",
                   i, wlog_addr[w0+i], wlog_data[w0+i], 8'(i), pay[i]);
        end
      end
    end
    do_reload();
    compared++;
    if (done !== 1'b0 || cpu_rst !== 1'b0 || bus.in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL basic_reload: done=%b cpu_rst=%b in_ready=%b required 0 0 1",
               done, cpu_rst, bus.in_ready);
    end
  endtask

  task automatic test_wrap();
    int w0 = wcnt;
    pay[0] = 8'hAA; pay[1] = 8'hBB;
    send_frame(2, 8'hFF, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    compared++;
    if (mem[8'hFF] !== 8'hAA || mem[8'h00] !== 8'hBB) begin
      mismatched++;
      $display("FAIL wrap_mem: mem[ff]=%h mem[00]=%h required aa bb", mem[8'hFF], mem[8'h00]);
    end
    compared++;
    if (wcnt - w0 !== 2 || wlog_addr[w0] !== 8'hFF || wlog_addr[w0+1] !== 8'h00) begin
      mismatched++;
      $display("FAIL wrap_addrs: count=%0d addrs=%h %h required 2 ff 00",
               wcnt - w0, wlog_addr[w0], wlog_addr[w0+1]);
    end
    compared++;
    if (done !== 1'b1) begin
      mismatched++;
      $display("FAIL wrap_done: done=%b required 1", done);
    end
    do_reload();
  endtask

`ifdef LOADER_CSUM_EN
  task automatic test_csum_error();
    int bad = 0;
    pay[0] = 8'h02; pay[1] = 8'h11; pay[2] = 8'h22;
    send_frame(3, 8'h00, 1'b0, 8'h07);
    for (int i = 0; i < 100; i++) begin
      if (err !== 1'b1 || cpu_rst !== 1'b0 || done !== 1'b0) bad++;
      @(negedge clk);
    end
    compared++;
    if (bad !== 0) begin
      mismatched++;
      $display("FAIL csum_error_hold: %0d bad cycles required 0", bad);
    end
    do_reload();
    compared++;
    if (err !== 1'b0 || bus.in_ready !== 1'b1 || cpu_rst !== 1'b0) begin
      mismatched++;
      $display("FAIL csum_error_reload: err=%b in_ready=%b cpu_rst=%b required 0 1 0",
               err, bus.in_ready, cpu_rst);
    end
  endtask
`endif

  task automatic test_stall();
    int w0 = wcnt;
    pay[0] = 8'h10; pay[1] = 8'h20; pay[2] = 8'h30; pay[3] = 8'h40;
    send_frame(4, 8'h40, 1'b1, 8'h00);
    repeat (4) @(negedge clk);
    compared++;
    if (wcnt - w0 !== 4) begin
      mismatched++;
      $display("FAIL stall_write_count: got %0d required 4", wcnt - w0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        compared++;
        if (wlog_addr[w0+i] !== 8'(8'h40 + i) || wlog_data[w0+i] !== pay[i] ||
            (i > 0 && wlog_cyc[w0+i] !== wlog_cyc[w0+i-1] + 2)) begin
          mismatched++;
          $display("FAIL stall_write%0d: addr=%h data=%h required %h %h",
                   i, wlog_addr[w0+i], wlog_data[w0+i], 8'(8'h40 + i), pay[i]);
        end
      end
    end
    compared++;
    if (done !== 1'b1) begin
      mismatched++;
      $display("FAIL stall_done: done=%b required 1", done);
    end
    do_reload();
  endtask

  task automatic test_reset_mid_frame();
    int bad = 0;
    watch = 1'b1;
    for (int i = 0; i < 10; i++) pay[i] = 8'(8'hD0 + i);
    send_byte(8'd10);
    send_byte(8'h80);
    for (int i = 0; i < 5; i++) send_byte(pay[i]);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (bus.in_ready !== 1'b0 || bus.mem_we !== 1'b0) begin
      mismatched++;
      $display("FAIL midrst_in_reset: in_ready=%b mem_we=%b required 0 0", bus.in_ready, bus.mem_we);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    watch = 1'b0;
    compared++;
    if (cpu_rst_high !== 0) begin
      mismatched++;
      $display("FAIL midrst_cpu_rst: high for %0d cycles required 0", cpu_rst_high);
    end
    for (int i = 0; i < 10; i++) pay[i] = 8'(8'h30 + i);
    send_frame(10, 8'h80, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 10; i++) if (mem[8'h80 + i] !== 8'(8'h30 + i)) bad++;
    compared++;
    if (bad !== 0 || done !== 1'b1) begin
      mismatched++;
      $display("FAIL midrst_resend: %0d wrong bytes done=%b required 0 1", bad, done);
    end
    do_reload();
  endtask

  task automatic test_full();
    int w0 = wcnt;
    int bad = 0;
    for (int i = 0; i < 256; i++) pay[i] = 8'(i) ^ 8'h5A;
    send_frame(256, 8'h10, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    compared++;
    if (wcnt - w0 !== 256) begin
      mismatched++;
      $display("FAIL full_write_count: got %0d required 256", wcnt - w0);
    end else begin
      for (int k = 0; k < 256; k++)
        if (wlog_addr[w0+k] !== 8'(8'h10 + k) || wlog_data[w0+k] !== pay[k]) bad++;
      compared++;
      if (bad !== 0) begin
        mismatched++;
        $display("FAIL full_writes: %0d wrong writes required 0", bad);
      end
    end
    compared++;
    if (done !== 1'b1 || cpu_rst !== 1'b1) begin
      mismatched++;
      $display("FAIL full_done: done=%b cpu_rst=%b required 1 1", done, cpu_rst);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
`ifdef LOADER_CSUM_EN
    test_csum_error();
`endif
    test_stall();
    test_reset_mid_frame();
    test_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
